// File: rtl/instr_assembler.sv
// instr_assembler: packs decoded MIPS-32 R/I/J field sets into 32-bit words,
// queues them in a small FIFO and streams them into instruction memory at
// consecutive word addresses. Acts as the program loader in front of the imem.
module instr_assembler #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               fmt,
   input  logic [5:0]               opcode,
   input  logic [4:0]               rs,
   input  logic [4:0]               rt,
   input  logic [4:0]               rd,
   input  logic [4:0]               shamt,
   input  logic [5:0]               funct,
   input  logic [15:0]              immediate,
   input  logic [25:0]              adress,
   output logic                     mem_we,
   input  logic                     mem_ack,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_fmt,
   output logic                     wrapped
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_BAD = 2'b11
   } fmt_e;

   logic [31:0]       slot_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wrapped_q, wrapped_d;
   logic              err_fmt_q, err_fmt_d;

   logic [31:0]       packed_word;
   logic              push;
   logic              pop;

   // Pack the field set according to its format; unused fields are ignored.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
      packed_word = '0;
      unique case (fmt_e'(fmt))
         FMT_R:   packed_word = {opcode, rs, rt, rd, shamt, funct};
         FMT_I:   packed_word = {opcode, rs, rt, immediate};
         FMT_J:   packed_word = {opcode, adress};
         FMT_BAD: packed_word = '0;
      endcase
   end

   // Handshakes: flush blocks pushes and discards any pop in the same cycle.
   assign in_ready  = (count_q < FULL_CNT) && !flush;
   assign mem_we    = (count_q != '0);
   assign push      = in_valid && in_ready && (fmt != FMT_BAD);
   assign pop       = mem_we && mem_ack && !flush;
   assign mem_wdata = mem_we ? slot_q[rd_ptr_q] : '0;
   assign mem_addr  = addr_q;
   assign count     = count_q;
   assign err_fmt   = err_fmt_q;
   assign wrapped   = wrapped_q;

   // Next-state for pointers, occupancy, address counter and status flags.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      addr_d    = addr_q;
      wrapped_d = wrapped_q;
      err_fmt_d = in_valid && in_ready && (fmt == FMT_BAD);
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         addr_d    = BASE;
         wrapped_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
            if (addr_q == ADDR_MAX) wrapped_d = 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         addr_q    <= BASE;
         wrapped_q <= 1'b0;
         err_fmt_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         wrapped_q <= wrapped_d;
         err_fmt_q <= err_fmt_d;
      end
   end

   // FIFO storage written at the tail on each accepted push.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count gates it, so stale slots are never observed.
      if (push) slot_q[wr_ptr_q] <= packed_word;
   end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed scenarios plus randomized
// traffic, compared each cycle against a queue-based reference model. Two
// instances share stimulus: default address width and a 2-bit address width.
module tb_instr_assembler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        mem_ack = 1'b0;
   logic [1:0]  fmt = 2'b00;
   logic [5:0]  opcode = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
   logic [5:0]  funct = '0;
   logic [15:0] immediate = '0;
   logic [25:0] adress = '0;

   logic        in_ready_a, mem_we_a, err_fmt_a, wrapped_a;
   logic [7:0]  mem_addr_a;
   logic [31:0] mem_wdata_a;
   logic [2:0]  count_a;
   logic        in_ready_b, mem_we_b, err_fmt_b, wrapped_b;
   logic [1:0]  mem_addr_b;
   logic [31:0] mem_wdata_b;
   logic [2:0]  count_b;

   instr_assembler #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .immediate(immediate), .adress(adress), .mem_we(mem_we_a), .mem_ack(mem_ack),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .count(count_a),
      .err_fmt(err_fmt_a), .wrapped(wrapped_a)
   );

   instr_assembler #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .immediate(immediate), .adress(adress), .mem_we(mem_we_b), .mem_ack(mem_ack),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .count(count_b),
      .err_fmt(err_fmt_b), .wrapped(wrapped_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: words waiting for imem, writes since reset/flush, pending err pulse.
   logic [31:0] exp_q[$];
   int          n_writes = 0;
   logic        err_exp = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_fields();
      case (fmt)
         2'b00:   return (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                         (32'(rd) << 11) | (32'(shamt) << 6) | 32'(funct);
         2'b01:   return (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(immediate);
         2'b10:   return (32'(opcode) << 26) | 32'(adress);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      n_writes = 0;
      err_exp  = 1'b0;
   endtask

   task automatic check_outputs();
      int sz;
      logic rdy;
      sz  = exp_q.size();
      rdy = (sz < DEPTH) && !flush;
      check("count_a", 32'(count_a), 32'(sz));
      check("count_b", 32'(count_b), 32'(sz));
      check("mem_we_a", 32'(mem_we_a), 32'(sz != 0));
      check("mem_we_b", 32'(mem_we_b), 32'(sz != 0));
      if (sz != 0) begin
         check("wdata_a", mem_wdata_a, exp_q[0]);
         check("wdata_b", mem_wdata_b, exp_q[0]);
      end
      check("addr_a", 32'(mem_addr_a), 32'(n_writes % 256));
      check("addr_b", 32'(mem_addr_b), 32'(n_writes % 4));
      check("wrapped_a", 32'(wrapped_a), 32'(n_writes >= 256));
      check("wrapped_b", 32'(wrapped_b), 32'(n_writes >= 4));
      check("in_ready_a", 32'(in_ready_a), 32'(rdy));
      check("in_ready_b", 32'(in_ready_b), 32'(rdy));
      check("err_fmt_a", 32'(err_fmt_a), 32'(err_exp));
      check("err_fmt_b", 32'(err_fmt_b), 32'(err_exp));
   endtask

   task automatic update_model();
      logic rdy;
      logic [31:0] w;
      rdy = (exp_q.size() < DEPTH) && !flush;
      w   = pack_fields();
      if (flush) begin
         model_reset();
      end else begin
         if (exp_q.size() != 0 && mem_ack) begin
            void'(exp_q.pop_front());
            n_writes++;
         end
         if (in_valid && rdy && fmt != 2'b11) exp_q.push_back(w);
         err_exp = in_valid && rdy && (fmt == 2'b11);
      end
   endtask

   // Called at a falling edge with this cycle's inputs already driven.
   task automatic cycle();
      #1;
      check_outputs();
      update_model();
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      fmt      = 2'b00;
   endtask

   task automatic set_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn);
      in_valid = 1'b1; fmt = 2'b00;
      opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
      immediate = 16'($urandom); adress = 26'($urandom);
   endtask

   task automatic set_random();
      int sel;
      sel       = int'($urandom_range(0, 7));
      fmt       = (sel < 3) ? 2'b00 : (sel < 5) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
      in_valid  = ($urandom_range(0, 99) < 60);
      opcode    = 6'($urandom);
      rs        = 5'($urandom);
      rt        = 5'($urandom);
      rd        = 5'($urandom);
      shamt     = 5'($urandom);
      funct     = 6'($urandom);
      immediate = 16'($urandom);
      adress    = 26'($urandom);
   endtask

   task automatic do_flush();
      idle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
   endtask

   initial begin
      // Reset state, asserted away from any clock edge.
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_mem_we", 32'(mem_we_a), 32'h0);
      check("rst_wdata", mem_wdata_a, 32'h0);
      check("rst_count", 32'(count_a), 32'h0);
      check("rst_addr", 32'(mem_addr_a), 32'h0);
      check("rst_wrapped", 32'(wrapped_a), 32'h0);
      check("rst_err", 32'(err_fmt_a), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type packing and one-cycle latency to mem_we.
      mem_ack = 1'b1;
      set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      cycle();
      idle();
      check("t1_mem_we", 32'(mem_we_a), 32'h1);
      check("t1_wdata", mem_wdata_a, 32'h00221820);
      check("t1_addr", 32'(mem_addr_a), 32'h0);
      cycle();

      // I then J back to back, addresses 0 and 1.
      do_flush();
      in_valid = 1'b1; fmt = 2'b01; opcode = 6'd8; rs = 5'd1; rt = 5'd2; immediate = 16'h0005;
      cycle();
      fmt = 2'b10; opcode = 6'd2; adress = 26'h10;
      check("t2_i_wdata", mem_wdata_a, 32'h20220005);
      check("t2_i_addr", 32'(mem_addr_a), 32'h0);
      cycle();
      idle();
      check("t2_j_wdata", mem_wdata_a, 32'h08000010);
      check("t2_j_addr", 32'(mem_addr_a), 32'h1);
      cycle();
      cycle();

      // Fill to full with imem stalled, then drain.
      do_flush();
      mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_r(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
         if (i == 4) begin
            check("t3_count_full", 32'(count_a), 32'd4);
            check("t3_ready_full", 32'(in_ready_a), 32'h0);
         end
         cycle();
      end
      idle();
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t3_drain_addr", 32'(mem_addr_a), 32'(i));
         if (i == 1) check("t3_ready_back", 32'(in_ready_a), 32'h1);
         cycle();
      end
      cycle();

      // Address wrap on the 2-bit instance.
      do_flush();
      mem_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            check("t5_addr_b", 32'(mem_addr_b), 32'((i - 1) % 4));
            check("t5_wrapped_b", 32'(wrapped_b), 32'(i == 5));
         end
         if (i < 5) begin
            in_valid = 1'b1; fmt = 2'b01; opcode = 6'($urandom); immediate = 16'($urandom);
         end else begin
            idle();
         end
         cycle();
      end

      // Illegal format: consumed, single err pulse, queue untouched.
      do_flush();
      mem_ack = 1'b0;
      set_r(6'd1, 5'd2, 5'd3, 5'd4, 5'd5, 6'd6);
      cycle();
      in_valid = 1'b1; fmt = 2'b11;
      check("t4_ready", 32'(in_ready_a), 32'h1);
      cycle();
      idle();
      check("t4_err_pulse", 32'(err_fmt_a), 32'h1);
      check("t4_count", 32'(count_a), 32'h1);
      cycle();
      check("t4_err_clear", 32'(err_fmt_a), 32'h0);
      check("t4_mem_we", 32'(mem_we_a), 32'h1);

      // Asynchronous reset, then flush, with three words queued and address advanced.
      for (int pass = 0; pass < 2; pass++) begin
         do_flush();
         mem_ack = 1'b1;
         for (int i = 0; i < 2; i++) begin
            set_r(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
            cycle();
         end
         idle();
         cycle();
         mem_ack = 1'b0;
         for (int i = 0; i < 3; i++) begin
            set_r(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
            cycle();
         end
         idle();
         check("t6_count_pre", 32'(count_a), 32'd3);
         check("t6_addr_pre", 32'(mem_addr_a), 32'd2);
         if (pass == 0) begin
            #3 rst_n = 1'b0;
            #1;
            model_reset();
            check("t6_rst_mem_we", 32'(mem_we_a), 32'h0);
            check("t6_rst_count", 32'(count_a), 32'h0);
            check("t6_rst_addr", 32'(mem_addr_a), 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            flush = 1'b1;
            cycle();
            idle();
            check("t6_fl_mem_we", 32'(mem_we_a), 32'h0);
            check("t6_fl_count", 32'(count_a), 32'h0);
            check("t6_fl_addr", 32'(mem_addr_a), 32'h0);
         end
      end

      // Randomized traffic with occasional flushes and imem stalls.
      for (int i = 0; i < 3000; i++) begin
         set_random();
         mem_ack = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 49) == 0);
         cycle();
      end
      idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
